// File: rtl/simple_counter_pkg.sv
// Shared constants and helpers for the simple_counter block.
// Holds the default counter width and the function that derives the
// default terminal count from a given width.
package simple_counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Largest value representable in 'width' bits. Computed in 64 bits
  // so that a 32-bit counter does not overflow the arithmetic.
  function automatic longint defaultMaxCount(input int width);
    return (longint'(1) << width) - longint'(1);
  endfunction

endpackage

// File: rtl/simple_counter.sv
// Free-running wrap-around counter.
// Counts 0..MAX_COUNT and wraps to 0. There is no enable and no hold state.
// Reset is asynchronous and active-low. Release of reset must already be
// synchronised to clk by the surrounding logic.
// Optional feature: define SIMPLE_COUNTER_TC_EN to add the 'tc' output, a
// combinational terminal-count decode that is high while count == MAX_COUNT.
module simple_counter
  import simple_counter_pkg::*;
#(
  parameter int     WIDTH     = DEFAULT_WIDTH,
  parameter longint MAX_COUNT = defaultMaxCount(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] count
`ifdef SIMPLE_COUNTER_TC_EN
  ,
  output logic             tc
`endif
);

  // Terminal value in the counter's own width.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

  // Reject illegal parameter combinations while the design is elaborated.
  if ((WIDTH < 1) || (WIDTH > 32)) begin : gen_bad_width
    $fatal(1, "simple_counter: WIDTH=%0d outside legal range 1..32", WIDTH);
  end
  if ((MAX_COUNT < 1) || (MAX_COUNT > defaultMaxCount(WIDTH))) begin : gen_bad_max
    $fatal(1, "simple_counter: MAX_COUNT=%0d outside legal range 1..2**WIDTH-1",
           MAX_COUNT);
  end

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next value: increment below the terminal value; at the terminal value,
  // or at any out-of-range value reached through corruption, go back to 0.
  always_comb begin
    count_d = '0;
    if (count_q < MAX_VAL) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register. Asynchronous clear forces 0 without waiting for clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

`ifdef SIMPLE_COUNTER_TC_EN
  // Terminal-count decode. Count is 0 in reset and MAX_VAL is never 0,
  // so tc is naturally low while reset is held.
  assign tc = (count_q == MAX_VAL);
`endif

endmodule

// File: tb/tb_simple_counter.sv
// Self-checking bench for simple_counter.
// Two instances share clk and reset: one with default parameters (wraps at
// 15) and one with MAX_COUNT=9. The reference model counts rising edges
// since reset release and derives each expected value as edges mod
// (MAX_COUNT+1).
module tb_simple_counter;

  logic       clk;
  logic       reset;
  logic [3:0] count16;
  logic [3:0] count10;
`ifdef SIMPLE_COUNTER_TC_EN
  logic       tc16;
  logic       tc10;
`endif

  int total;
  int bad;
  int edgesSinceRelease;
  int seenTen;

  typedef struct {
    int         edges;
    logic [3:0] exp16;
    logic [3:0] exp10;
  } vec_t;

  vec_t vecs[7];

  simple_counter dut (
    .clk   (clk),
    .reset (reset),
    .count (count16)
`ifdef SIMPLE_COUNTER_TC_EN
    ,
    .tc    (tc16)
`endif
  );

  simple_counter #(.WIDTH(4), .MAX_COUNT(9)) dut9 (
    .clk   (clk),
    .reset (reset),
    .count (count10)
`ifdef SIMPLE_COUNTER_TC_EN
    ,
    .tc    (tc10)
`endif
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one value; X/Z on the actual side also counts as a failure.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at time %0t",
               name, actual, expected, $time);
    end
  endtask

  // Check both instances against the edge-count model.
  task automatic checkModel(input string tag);
    checkOutput({tag, "/count16"}, 32'(count16), 32'(edgesSinceRelease % 16));
    checkOutput({tag, "/count10"}, 32'(count10), 32'(edgesSinceRelease % 10));
`ifdef SIMPLE_COUNTER_TC_EN
    checkOutput({tag, "/tc16"}, 32'(tc16), 32'((edgesSinceRelease % 16) == 15));
    checkOutput({tag, "/tc10"}, 32'(tc10), 32'((edgesSinceRelease % 10) == 9));
`endif
  endtask

  // Check both counters read zero (reset state).
  task automatic checkZero(input string tag);
    checkOutput({tag, "/count16"}, 32'(count16), 32'd0);
    checkOutput({tag, "/count10"}, 32'(count10), 32'd0);
`ifdef SIMPLE_COUNTER_TC_EN
    checkOutput({tag, "/tc16"}, 32'(tc16), 32'd0);
    checkOutput({tag, "/tc10"}, 32'(tc10), 32'd0);
`endif
  endtask

  // Assert reset between edges, hold it 3 cycles, release on a falling edge.
  task automatic applyStimulus();
    @(negedge clk);
    #2 reset = 1'b0;
    #1 checkZero("asyncReset");
    repeat (3) begin
      @(negedge clk);
      checkZero("holdReset");
    end
    reset = 1'b1;
    edgesSinceRelease = 0;
  endtask

  // Let k rising edges pass, sampling and checking after each on the falling edge.
  task automatic runEdges(input int k, input string tag, input bit checkEach);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      edgesSinceRelease++;
      if (count10 == 4'd10) seenTen++;
      if (checkEach) checkModel(tag);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    seenTen = 0;
    edgesSinceRelease = 0;

    vecs[0] = '{edges: 1,    exp16: 4'd1,  exp10: 4'd1};
    vecs[1] = '{edges: 9,    exp16: 4'd9,  exp10: 4'd9};
    vecs[2] = '{edges: 10,   exp16: 4'd10, exp10: 4'd0};
    vecs[3] = '{edges: 15,   exp16: 4'd15, exp10: 4'd5};
    vecs[4] = '{edges: 16,   exp16: 4'd0,  exp10: 4'd6};
    vecs[5] = '{edges: 37,   exp16: 4'd5,  exp10: 4'd7};
    vecs[6] = '{edges: 5000, exp16: 4'd8,  exp10: 4'd0};

    // Reset asserted from time zero; the counters must read 0 before any edge.
    reset = 1'b0;
    #1 checkZero("initialReset");
    applyStimulus();

    // First edge after release gives 1, then the full wrap of both instances.
    runEdges(1, "firstEdge", 1'b1);
    checkOutput("firstEdgeIsOne", 32'(count16), 32'd1);
    runEdges(31, "wrapSeq", 1'b1);

    // Table-driven: fresh reset, then run N edges and compare to fixed values.
    foreach (vecs[i]) begin
      applyStimulus();
      runEdges(vecs[i].edges, "vec", 1'b0);
      checkOutput($sformatf("vec%0d/count16", i), 32'(count16), 32'(vecs[i].exp16));
      checkOutput($sformatf("vec%0d/count10", i), 32'(count10), 32'(vecs[i].exp10));
    end

    // Asynchronous reset in the middle of a run at count 7, then restart.
    applyStimulus();
    runEdges(7, "toSeven", 1'b1);
    checkOutput("atSeven", 32'(count16), 32'd7);
    #3 reset = 1'b0;
    #1 checkOutput("midReset/count16", 32'(count16), 32'd0);
    checkOutput("midReset/count10", 32'(count10), 32'd0);
    @(negedge clk);
    checkZero("midResetHeld");
    reset = 1'b1;
    edgesSinceRelease = 0;
    runEdges(3, "restart", 1'b1);
    checkOutput("restartThree", 32'(count16), 32'd3);

    // MAX_COUNT=9 instance never shows 10 over 100 cycles.
    seenTen = 0;
    runEdges(100, "noTen", 1'b1);
    checkOutput("neverTen", 32'(seenTen), 32'd0);

    // Randomized run lengths with reset pulses at random points between edges.
    for (int r = 0; r < 25; r++) begin
      runEdges(int'($urandom_range(1, 40)), "random", 1'b1);
      #($urandom_range(1, 4)) reset = 1'b0;
      #0.5;
      checkZero("randomReset");
      repeat ($urandom_range(1, 3)) begin
        @(negedge clk);
        checkZero("randomHold");
      end
      reset = 1'b1;
      edgesSinceRelease = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
